pe_verify_serializer: RTL



---
 rtl/pe_verify_serializer_pkg.sv | 29 ++
 rtl/pe_verify_serializer_shifter.sv | 72 +++++++
 rtl/pe_verify_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pe_verify_serializer_pkg.sv
// Shared definitions for the PE verification serializer: bus widths,
// frame geometry and FSM state encodings.
package pe_verify_serializer_pkg;

   localparam int unsigned PDATASIZE   = 16;
   localparam int unsigned CDATASIZE   = 15;

   // Selected-PE signal bus width and full frame width
   // (4 sel + 4 rst_n_test + 16 scan_in_test + signal bus).
   localparam int unsigned PEV_SIG_W   = PDATASIZE + CDATASIZE + 9;
   localparam int unsigned PEV_FRAME_W = PDATASIZE + CDATASIZE + 33;
   localparam int unsigned PEV_HDR_W   = 24;

   typedef enum logic [2:0] {
      PEV_ST_IDLE    = 3'd0,
      PEV_ST_SETTLE  = 3'd1,
      PEV_ST_CAPTURE = 3'd2,
      PEV_ST_SHIFT   = 3'd3,
      PEV_ST_NEXT    = 3'd4
   } pev_state_e;

   // Number of LANES-wide beats needed to cover a frame, rounding up so a
   // frame that is not a multiple of LANES is zero-padded at the LSB end.
   function automatic int unsigned pev_beats(input int unsigned frame_w,
                                             input int unsigned lanes);
      return (frame_w + lanes - 1) / lanes;
   endfunction

endpackage

// File: rtl/pe_verify_serializer_shifter.sv
// Frame register and MSB-first LANES-wide shifter with a valid/ready
// output port. Loaded by the FSM once per frame; reports the accepted
// final beat back to the FSM.
module pe_verify_shifter
   import pe_verify_serializer_pkg::*;
#(
   parameter int unsigned FRAME_W = PEV_FRAME_W,
   parameter int unsigned LANES   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_abort,
   input  logic [FRAME_W-1:0] i_frame,
   input  logic               i_ready,
   output logic [LANES-1:0]   o_data,
   output logic               o_valid,
   output logic               o_last,
   output logic               o_frame_done
);

   localparam int unsigned BEATS  = pev_beats(FRAME_W, LANES);
   localparam int unsigned PAD_W  = BEATS * LANES;
   localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCNT_W-1:0] BEAT_LD = BCNT_W'(BEATS - 1);

   logic [PAD_W-1:0]  r_frame;
   logic [PAD_W-1:0]  w_padded;
   logic [BCNT_W-1:0] r_beat;
   logic              r_active;
   logic              w_accept;
   logic              w_final;

   // Left-justify the captured frame so padding trails the last real bits.
   always_comb begin
      w_padded                      = '0;
      w_padded[PAD_W-1 -: FRAME_W]  = i_frame;
   end

   assign w_accept = r_active && i_ready;
   assign w_final  = (r_beat == '0);

   // Frame/beat state: load, shift on each accepted beat, drop on abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame  <= '0;
         r_beat   <= '0;
         r_active <= 1'b0;
      end else if (i_abort) begin
         r_frame  <= '0;
         r_beat   <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_frame  <= w_padded;
         r_beat   <= BEAT_LD;
         r_active <= 1'b1;
      end else if (w_accept) begin
         r_frame <= r_frame << LANES;
         if (w_final) begin
            r_active <= 1'b0;
         end else begin
            r_beat <= r_beat - BCNT_W'(1);
         end
      end
   end

   assign o_data       = r_frame[PAD_W-1 -: LANES];
   assign o_valid      = r_active;
   assign o_last       = r_active && w_final;
   assign o_frame_done = w_accept && w_final;

endmodule

// File: rtl/pe_verify_serializer.sv
// PE verification serializer: steers the PE verify mux, waits for the
// selected test bus to settle, captures it as one frame and streams the
// frame out over a valid/ready port. Single-PE or 16-PE sweep.
module pe_verify_serializer
   import pe_verify_serializer_pkg::*;
#(
   parameter int unsigned SIG_W      = PEV_SIG_W,
   parameter int unsigned LANES      = 4,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode_auto,
   input  logic [3:0]       sel_manual,
   input  logic             abort,
   output logic [3:0]       pe_verify_sel,
   input  logic [3:0]       rst_n_test,
   input  logic [15:0]      scan_in_test,
   input  logic [SIG_W-1:0] signal_test,
   output logic [LANES-1:0] ser_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned FRAME_W   = PEV_HDR_W + SIG_W;
   localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC);

   pev_state_e         r_state;
   pev_state_e         w_state_nxt;
   logic [7:0]         r_settle;
   logic [3:0]         r_sel;
   logic               r_auto;
   logic               w_sweep_more;
   logic               w_load;
   logic               w_frame_done;
   logic [FRAME_W-1:0] w_frame;

   assign pe_verify_sel = r_sel;
   assign w_sweep_more  = r_auto && (r_sel != 4'hF);
   assign w_frame       = {r_sel, rst_n_test, scan_in_test, signal_test};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PEV_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort overrides every transition, including start.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         PEV_ST_IDLE:    if (start) w_state_nxt = PEV_ST_SETTLE;
         PEV_ST_SETTLE:  if (r_settle == 8'd1) w_state_nxt = PEV_ST_CAPTURE;
         PEV_ST_CAPTURE: w_state_nxt = PEV_ST_SHIFT;
         PEV_ST_SHIFT:   if (w_frame_done) w_state_nxt = PEV_ST_NEXT;
         PEV_ST_NEXT:    w_state_nxt = w_sweep_more ? PEV_ST_SETTLE : PEV_ST_IDLE;
         default:        w_state_nxt = PEV_ST_IDLE;
      endcase
      if (abort) begin
         w_state_nxt = PEV_ST_IDLE;
      end
   end

   // FSM outputs; load and done are masked by abort so an aborted run
   // neither arms the shifter nor reports completion.
   always_comb begin
      busy   = (r_state != PEV_ST_IDLE);
      w_load = (r_state == PEV_ST_CAPTURE) && !abort;
      done   = (r_state == PEV_ST_NEXT) && !w_sweep_more && !abort;
   end

   // Select, mode and settle counter; held across abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel    <= '0;
         r_auto   <= 1'b0;
         r_settle <= '0;
      end else if (!abort) begin
         case (r_state)
            PEV_ST_IDLE: begin
               if (start) begin
                  r_sel    <= mode_auto ? 4'h0 : sel_manual;
                  r_auto   <= mode_auto;
                  r_settle <= SETTLE_LD;
               end
            end
            PEV_ST_SETTLE: r_settle <= r_settle - 8'd1;
            PEV_ST_NEXT: begin
               if (w_sweep_more) begin
                  r_sel    <= r_sel + 4'd1;
                  r_settle <= SETTLE_LD;
               end
            end
            default: ;
         endcase
      end
   end

   pe_verify_shifter #(
      .FRAME_W (FRAME_W),
      .LANES   (LANES)
   ) u_shifter (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_load       (w_load),
      .i_abort      (abort),
      .i_frame      (w_frame),
      .i_ready      (ser_ready),
      .o_data       (ser_data),
      .o_valid      (ser_valid),
      .o_last       (ser_last),
      .o_frame_done (w_frame_done)
   );

endmodule
